vending_machine_pn: RTL and testbench

//  Parametrised successor to the two-coin vending FSM. Generalises price and coin values, and adds:
//  - cancel/refund
//  - stock tracking with sold-out and refill
//  - unit-by-unit change dispensing under a valid/ack handshake

---
 rtl/vending_machine_pn.sv | 114 +++++++++++
 tb/tb_vending_machine_pn.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/vending_machine_pn.sv
// Parametrised vending controller: coin credit, cancel/refund, stock tracking and
// unit-by-unit change dispensing under a valid/ack handshake. All outputs registered.
module vending_machine_pn #(
  parameter int PRICE       = 5,
  parameter int COIN_LO_VAL = 1,
  parameter int COIN_HI_VAL = 2,
  parameter int CREDIT_W    = 4,
  parameter int STOCK_INIT  = 4,
  parameter int STOCK_W     = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [1:0]          coin,
  input  logic                cancel,
  input  logic                change_ack,
  input  logic                refill,
  output logic                sell,
  output logic                coin_reject,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_rem,
  output logic [CREDIT_W-1:0] credit,
  output logic [STOCK_W-1:0]  stock,
  output logic                sold_out
);

  localparam int SW = CREDIT_W + 1;
  localparam logic [SW-1:0] PRICE_S  = SW'(PRICE);
  localparam logic [SW-1:0] LO_VAL_S = SW'(COIN_LO_VAL);
  localparam logic [SW-1:0] HI_VAL_S = SW'(COIN_HI_VAL);

  typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;

  state_t              state, state_next;
  logic [CREDIT_W-1:0] credit_next, change_rem_next;
  logic [STOCK_W-1:0]  stock_next;
  logic                sell_next, coin_reject_next;
  logic                coin_ok, accept, ack_take, cancel_take;
  logic [SW-1:0]       coin_val, sum;

  // Decode shared by next-state and datapath logic.
  always_comb begin
    coin_ok     = (coin == 2'b01) || (coin == 2'b10);
    coin_val    = (coin == 2'b10) ? HI_VAL_S : LO_VAL_S;
    sum         = {1'b0, credit} + coin_val;
    accept      = ((state == IDLE) || (state == COLLECT)) && !sold_out && coin_ok && !cancel;
    cancel_take = (state == COLLECT) && cancel;
    ack_take    = change_ack && (change_rem != '0);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      credit       <= '0;
      change_rem   <= '0;
      stock        <= STOCK_W'(STOCK_INIT);
      sell         <= 1'b0;
      coin_reject  <= 1'b0;
      change_valid <= 1'b0;
      sold_out     <= 1'b0;
    end else begin
      state        <= state_next;
      credit       <= credit_next;
      change_rem   <= change_rem_next;
      stock        <= stock_next;
      sell         <= sell_next;
      coin_reject  <= coin_reject_next;
      change_valid <= (change_rem_next != '0);
      sold_out     <= (stock_next == '0);
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, COLLECT: begin
        if (cancel_take)
          state_next = CHANGE;
        else if (accept)
          state_next = (sum < PRICE_S) ? COLLECT : VEND;
      end
      VEND:    state_next = (change_rem_next != '0) ? CHANGE : IDLE;
      CHANGE:  if (change_rem_next == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    credit_next      = credit;
    change_rem_next  = ack_take ? change_rem - CREDIT_W'(1) : change_rem;
    stock_next       = stock;
    sell_next        = 1'b0;
    coin_reject_next = (coin != 2'b00) && !accept;
    if (cancel_take) begin
      change_rem_next = credit;
      credit_next     = '0;
    end else if (accept) begin
      if (sum < PRICE_S) begin
        credit_next = sum[CREDIT_W-1:0];
      end else begin
        credit_next     = '0;
        change_rem_next = CREDIT_W'(sum - PRICE_S);
        stock_next      = stock - STOCK_W'(1);
        sell_next       = 1'b1;
      end
    end
    // Refill wins over a simultaneous vend decrement.
    if (refill)
      stock_next = STOCK_W'(STOCK_INIT);
  end

endmodule

// File: tb/tb_vending_machine_pn.sv
// Directed plus randomized bench for vending_machine_pn (default parameters),
// checked against a cycle-level behavioural model of the vending rules.
module tb_vending_machine_pn;

  localparam int PRICE = 5;
  localparam int LO_V  = 1;
  localparam int HI_V  = 2;
  localparam int SINIT = 4;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [1:0] coin = 2'b00;
  logic       cancel = 1'b0;
  logic       change_ack = 1'b0;
  logic       refill = 1'b0;
  logic       sell, coin_reject, change_valid, sold_out;
  logic [3:0] change_rem, credit, stock;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state
  int m_credit, m_rem, m_stock;
  bit m_sell, m_rej;

  vending_machine_pn dut (
    .clk(clk), .rstn(rstn), .coin(coin), .cancel(cancel),
    .change_ack(change_ack), .refill(refill), .sell(sell),
    .coin_reject(coin_reject), .change_valid(change_valid),
    .change_rem(change_rem), .credit(credit), .stock(stock), .sold_out(sold_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs_raw, input int expv, input bit has_x);
    n_vec++;
    assert (!has_x && obs_raw === expv)
    else begin
      n_err++;
      $error("FAIL %s observed=%0d%s expected=%0d", tag, obs_raw, has_x ? "(X)" : "", expv);
    end
  endtask

  task automatic check_all();
    chk("sell",         int'(sell),         int'(m_sell),       $isunknown(sell));
    chk("coin_reject",  int'(coin_reject),  int'(m_rej),        $isunknown(coin_reject));
    chk("change_valid", int'(change_valid), int'(m_rem != 0),   $isunknown(change_valid));
    chk("change_rem",   int'(change_rem),   m_rem,              $isunknown(change_rem));
    chk("credit",       int'(credit),       m_credit,           $isunknown(credit));
    chk("stock",        int'(stock),        m_stock,            $isunknown(stock));
    chk("sold_out",     int'(sold_out),     int'(m_stock == 0), $isunknown(sold_out));
  endtask

  task automatic model_reset();
    m_credit = 0; m_rem = 0; m_stock = SINIT; m_sell = 0; m_rej = 0;
  endtask

  // One clock of the vending rules. Machine is "taking coins" when it is not
  // vending this cycle and owes no change.
  task automatic model_update(input logic [1:0] c, input bit cn, input bit ack, input bit rf);
    bit accept;
    int v, s, n_credit, n_rem, n_stock;
    bit n_sell;
    accept   = !m_sell && m_rem == 0 && m_stock != 0 && (c == 2'b01 || c == 2'b10) && !cn;
    n_credit = m_credit;
    n_rem    = (ack && m_rem != 0) ? m_rem - 1 : m_rem;
    n_stock  = m_stock;
    n_sell   = 0;
    if (cn && m_credit > 0) begin
      n_rem    = m_credit;
      n_credit = 0;
    end else if (accept) begin
      v = (c == 2'b10) ? HI_V : LO_V;
      s = m_credit + v;
      if (s < PRICE) n_credit = s;
      else begin
        n_credit = 0;
        n_rem    = s - PRICE;
        n_stock  = m_stock - 1;
        n_sell   = 1;
      end
    end
    if (rf) n_stock = SINIT;
    m_rej    = (c != 2'b00) && !accept;
    m_credit = n_credit;
    m_rem    = n_rem;
    m_stock  = n_stock;
    m_sell   = n_sell;
  endtask

  task automatic step(input logic [1:0] c, input bit cn, input bit ack, input bit rf);
    @(negedge clk);
    coin = c; cancel = cn; change_ack = ack; refill = rf;
    model_update(c, cn, ack, rf);
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    logic [1:0] rc;
    model_reset();
    // Reset state
    #12;
    check_all();
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    check_all();

    // 1: 10,10,01 -> exact price, no change
    step(2'b10, 0, 0, 0);
    step(2'b10, 0, 0, 0);
    step(2'b01, 0, 0, 0);
    chk("t1_sell", int'(sell), 1, $isunknown(sell));
    chk("t1_stock", int'(stock), 3, $isunknown(stock));
    step(2'b00, 0, 0, 0);

    // 2: 10,10,10 -> one unit change, drained by one ack
    step(2'b10, 0, 0, 0);
    step(2'b10, 0, 0, 0);
    step(2'b10, 0, 0, 0);
    step(2'b00, 0, 0, 0);
    chk("t2_rem", int'(change_rem), 1, $isunknown(change_rem));
    step(2'b00, 0, 1, 0);

    // 3: 10,01, cancel -> refund 3 drained by held ack
    step(2'b10, 0, 0, 0);
    step(2'b01, 0, 0, 0);
    step(2'b00, 1, 0, 0);
    chk("t3_rem", int'(change_rem), 3, $isunknown(change_rem));
    step(2'b00, 0, 1, 0);
    step(2'b00, 0, 1, 0);
    step(2'b00, 0, 1, 0);
    step(2'b00, 0, 1, 0);

    // 4: invalid code, coin during CHANGE, coin with cancel
    step(2'b11, 0, 0, 0);
    step(2'b01, 0, 0, 0);
    step(2'b00, 1, 0, 0);
    step(2'b01, 0, 0, 0);
    chk("t4_reject", int'(coin_reject), 1, $isunknown(coin_reject));
    step(2'b00, 0, 1, 0);
    step(2'b10, 1, 0, 0);

    // 5: drain stock to sold out, reject, refill, refill racing a vend
    for (int k = 0; k < 2; k++) begin
      step(2'b10, 0, 0, 0);
      step(2'b10, 0, 0, 0);
      step(2'b01, 0, 0, 0);
      step(2'b00, 0, 0, 0);
    end
    chk("t5_sold_out", int'(sold_out), 1, $isunknown(sold_out));
    step(2'b01, 0, 0, 0);
    step(2'b00, 0, 0, 1);
    step(2'b01, 0, 0, 0);
    step(2'b10, 0, 0, 0);
    step(2'b10, 0, 0, 1);
    chk("t5_refill_vend_stock", int'(stock), SINIT, $isunknown(stock));
    step(2'b00, 0, 0, 0);

    // 6: asynchronous reset while owing 2 units of change
    step(2'b10, 0, 0, 0);
    step(2'b00, 1, 0, 0);
    @(negedge clk);
    coin = 2'b00; cancel = 0; change_ack = 0; refill = 0;
    #2 rstn = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    check_all();
    step(2'b01, 0, 0, 0);
    chk("t6_credit", int'(credit), 1, $isunknown(credit));

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      rc = 2'($urandom_range(0, 3));
      step(rc, ($urandom_range(0, 7) == 0), ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 19) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
